serial_nibble_receiver: RTL and testbench

SERIAL_NIBBLE_RECEIVER -- requirements
Module: serial_nibble_receiver

---
 rtl/serial_rx_pkg.sv | 16 +
 rtl/serial_rx_shifter.sv | 41 ++++
 rtl/serial_nibble_receiver.sv | 125 ++++++++++++
 tb/tb_serial_nibble_receiver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial nibble receiver.
// Holds the frame FSM encoding, frame width and bit-order selector values.
package serial_rx_pkg;

    localparam int FRAME_BITS = 4;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/serial_rx_shifter.sv
// Frame shift register: clear wins over enable, direction picks the insertion end.
// Updates on the same edge as the strobe; no backpressure of its own.
module serial_rx_shifter
    import serial_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  din,
    output logic [FRAME_BITS-1:0] sh
);

    logic [FRAME_BITS-1:0] sh_q;
    logic [FRAME_BITS-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (clr) begin
            sh_d = '0;
        end else if (en) begin
            if (dir == DIR_LSB_FIRST) begin
                sh_d = {din, sh_q[FRAME_BITS-1:1]};
            end else begin
                sh_d = {sh_q[FRAME_BITS-2:0], din};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign sh = sh_q;

endmodule

// File: rtl/serial_nibble_receiver.sv
// Receives start + 4 data bits + even parity; nibble appears one clock after the parity strobe.
// Output is a single-entry holding register: a good frame arriving while it is full and not drained is dropped with ovr_21.
module serial_nibble_receiver
    import serial_rx_pkg::*;
#(
    parameter int FRAME_BITS = 4
) (
    input  logic                  clk_21,
    input  logic                  rst_21,
    input  logic                  sin_21,
    input  logic                  sen_21,
    input  logic                  start_21,
    input  logic                  dir_21,
    input  logic                  ready_21,
    output logic [FRAME_BITS-1:0] dout_21,
    output logic                  valid_21,
    output logic                  busy_21,
    output logic                  perr_21,
    output logic                  ovr_21
);

    localparam logic [1:0] CNT_LAST = 2'(FRAME_BITS - 1);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic [FRAME_BITS-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ovr_q, ovr_d;

    logic                  sh_clr;
    logic                  sh_en;
    logic [FRAME_BITS-1:0] sh;

    serial_rx_shifter u_shifter (
        .clk (clk_21),
        .rst (rst_21),
        .clr (sh_clr),
        .en  (sh_en),
        .dir (dir_q),
        .din (sin_21),
        .sh  (sh)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        perr_d  = 1'b0;
        ovr_d   = 1'b0;
        sh_clr  = 1'b0;
        sh_en   = 1'b0;

        // Consumer drain; a same-cycle load below overrides the clear.
        if (valid_q && ready_21) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_21) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    dir_d   = dir_21;
                    sh_clr  = 1'b1;
                end
            end
            DATA: begin
                if (sen_21) begin
                    sh_en = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sen_21) begin
                    state_d = IDLE;
                    if (^{sh, sin_21}) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || ready_21) begin
                        dout_d  = sh;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_21 or posedge rst_21) begin
        if (rst_21) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout_21  = dout_q;
    assign valid_21 = valid_q;
    assign busy_21  = (state_q != IDLE);
    assign perr_21  = perr_q;
    assign ovr_21   = ovr_q;

endmodule

// File: tb/tb_serial_nibble_receiver.sv
// Directed bench for the serial nibble receiver: reset, both bit orders, parity error,
// overrun and same-cycle reload, mid-frame reset, strobe gaps with stray start markers.
module tb_serial_nibble_receiver;

    logic       clk_21   = 1'b0;
    logic       rst_21   = 1'b1;
    logic       sin_21   = 1'b0;
    logic       sen_21   = 1'b0;
    logic       start_21 = 1'b0;
    logic       dir_21   = 1'b0;
    logic       ready_21 = 1'b0;
    logic [3:0] dout_21;
    logic       valid_21;
    logic       busy_21;
    logic       perr_21;
    logic       ovr_21;

    int total = 0;
    int bad   = 0;

    serial_nibble_receiver #(.FRAME_BITS(4)) dut (
        .clk_21   (clk_21),
        .rst_21   (rst_21),
        .sin_21   (sin_21),
        .sen_21   (sen_21),
        .start_21 (start_21),
        .dir_21   (dir_21),
        .ready_21 (ready_21),
        .dout_21  (dout_21),
        .valid_21 (valid_21),
        .busy_21  (busy_21),
        .perr_21  (perr_21),
        .ovr_21   (ovr_21)
    );

    always #5 clk_21 = ~clk_21;

    task automatic cyc();
        @(posedge clk_21);
        #1;
    endtask

    // Start strobe; sen_21 is raised alongside it to show that strobe is ignored.
    task automatic send_start(input logic d);
        start_21 = 1'b1;
        dir_21   = d;
        sen_21   = 1'b1;
        sin_21   = 1'b1;
        cyc();
        start_21 = 1'b0;
        sen_21   = 1'b0;
        sin_21   = 1'b0;
    endtask

    // Idle gap cycles carry a stray start marker and an inverted data bit.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            sen_21   = 1'b0;
            sin_21   = ~b;
            start_21 = 1'b1;
            cyc();
        end
        start_21 = 1'b0;
        sen_21   = 1'b1;
        sin_21   = b;
        cyc();
        sen_21 = 1'b0;
        sin_21 = 1'b0;
    endtask

    // bits[3] goes on the wire first.
    task automatic send_data(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) send_bit(bits[i], 0);
    endtask

    task automatic test_reset();
        rst_21 = 1'b1;
        cyc();
        total++; if (dout_21 !== 4'h0) begin bad++; $display("FAIL reset_dout: actual=%h required=%h", dout_21, 4'h0); end
        total++; if (valid_21 !== 1'b0) begin bad++; $display("FAIL reset_valid: actual=%b required=0", valid_21); end
        total++; if (busy_21 !== 1'b0) begin bad++; $display("FAIL reset_busy: actual=%b required=0", busy_21); end
        total++; if (perr_21 !== 1'b0) begin bad++; $display("FAIL reset_perr: actual=%b required=0", perr_21); end
        total++; if (ovr_21 !== 1'b0) begin bad++; $display("FAIL reset_ovr: actual=%b required=0", ovr_21); end
        rst_21 = 1'b0;
        cyc();
    endtask

    task automatic test_msb_first();
        ready_21 = 1'b1;   // no effect while nothing is valid
        send_start(1'b0);
        total++; if (busy_21 !== 1'b1) begin bad++; $display("FAIL msb_busy: actual=%b required=1", busy_21); end
        send_data(4'b1011);
        total++; if (valid_21 !== 1'b0) begin bad++; $display("FAIL msb_early_valid: actual=%b required=0", valid_21); end
        ready_21 = 1'b0;
        send_bit(1'b1, 0);
        total++; if (valid_21 !== 1'b1) begin bad++; $display("FAIL msb_valid: actual=%b required=1", valid_21); end
        total++; if (dout_21 !== 4'b1011) begin bad++; $display("FAIL msb_dout: actual=%b required=1011", dout_21); end
        total++; if (busy_21 !== 1'b0) begin bad++; $display("FAIL msb_idle: actual=%b required=0", busy_21); end
        cyc();
        total++; if (dout_21 !== 4'b1011 || valid_21 !== 1'b1) begin bad++; $display("FAIL msb_hold: actual=%b/%b required=1011/1", dout_21, valid_21); end
        ready_21 = 1'b1;
        cyc();
        ready_21 = 1'b0;
        total++; if (valid_21 !== 1'b0) begin bad++; $display("FAIL msb_drain: actual=%b required=0", valid_21); end
    endtask

    task automatic test_lsb_first();
        send_start(1'b1);
        send_data(4'b1011);
        send_bit(1'b1, 0);
        total++; if (dout_21 !== 4'b1101 || valid_21 !== 1'b1) begin bad++; $display("FAIL lsb_dout: actual=%b/%b required=1101/1", dout_21, valid_21); end
        ready_21 = 1'b1;
        cyc();
        ready_21 = 1'b0;
    endtask

    task automatic test_parity_error();
        send_start(1'b0);
        send_data(4'b0001);
        send_bit(1'b0, 0);
        total++; if (perr_21 !== 1'b1) begin bad++; $display("FAIL perr_pulse: actual=%b required=1", perr_21); end
        total++; if (valid_21 !== 1'b0) begin bad++; $display("FAIL perr_valid: actual=%b required=0", valid_21); end
        total++; if (busy_21 !== 1'b0) begin bad++; $display("FAIL perr_idle: actual=%b required=0", busy_21); end
        cyc();
        total++; if (perr_21 !== 1'b0) begin bad++; $display("FAIL perr_one_cycle: actual=%b required=0", perr_21); end
    endtask

    task automatic test_overrun();
        send_start(1'b0);
        send_data(4'h3);
        send_bit(1'b0, 0);
        total++; if (dout_21 !== 4'h3 || valid_21 !== 1'b1) begin bad++; $display("FAIL ovr_frame_a: actual=%h/%b required=3/1", dout_21, valid_21); end
        send_start(1'b0);
        send_data(4'h5);
        send_bit(1'b0, 0);
        total++; if (ovr_21 !== 1'b1) begin bad++; $display("FAIL ovr_pulse: actual=%b required=1", ovr_21); end
        total++; if (dout_21 !== 4'h3 || valid_21 !== 1'b1) begin bad++; $display("FAIL ovr_held: actual=%h/%b required=3/1", dout_21, valid_21); end
        cyc();
        total++; if (ovr_21 !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle: actual=%b required=0", ovr_21); end
        send_start(1'b0);
        send_data(4'h5);
        ready_21 = 1'b1;
        send_bit(1'b0, 0);
        ready_21 = 1'b0;
        total++; if (dout_21 !== 4'h5 || valid_21 !== 1'b1) begin bad++; $display("FAIL reload: actual=%h/%b required=5/1", dout_21, valid_21); end
        total++; if (ovr_21 !== 1'b0) begin bad++; $display("FAIL reload_ovr: actual=%b required=0", ovr_21); end
        ready_21 = 1'b1;
        cyc();
        ready_21 = 1'b0;
    endtask

    task automatic test_reset_midframe();
        send_start(1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst_21 = 1'b1;
        #1;
        total++; if (busy_21 !== 1'b0) begin bad++; $display("FAIL rst_busy: actual=%b required=0", busy_21); end
        total++; if (dout_21 !== 4'h0 || valid_21 !== 1'b0) begin bad++; $display("FAIL rst_out: actual=%h/%b required=0/0", dout_21, valid_21); end
        cyc();
        rst_21 = 1'b0;
        cyc();
        // Bits without a fresh start must not form a frame.
        send_data(4'b1010);
        send_bit(1'b0, 0);
        total++; if (valid_21 !== 1'b0 || busy_21 !== 1'b0 || perr_21 !== 1'b0 || ovr_21 !== 1'b0) begin bad++; $display("FAIL rst_nostart: actual=v%b b%b p%b o%b required=all 0", valid_21, busy_21, perr_21, ovr_21); end
        send_start(1'b0);
        send_data(4'hA);
        send_bit(1'b0, 0);
        total++; if (dout_21 !== 4'hA || valid_21 !== 1'b1) begin bad++; $display("FAIL rst_next_frame: actual=%h/%b required=a/1", dout_21, valid_21); end
        ready_21 = 1'b1;
        cyc();
        ready_21 = 1'b0;
    endtask

    task automatic test_gaps();
        send_start(1'b0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 1);
        send_bit(1'b1, 2);
        send_bit(1'b1, 3);
        total++; if (busy_21 !== 1'b1 || valid_21 !== 1'b0) begin bad++; $display("FAIL gap_busy: actual=%b/%b required=1/0", busy_21, valid_21); end
        send_bit(1'b1, 2);
        total++; if (dout_21 !== 4'b1011 || valid_21 !== 1'b1) begin bad++; $display("FAIL gap_dout: actual=%b/%b required=1011/1", dout_21, valid_21); end
        total++; if (perr_21 !== 1'b0) begin bad++; $display("FAIL gap_perr: actual=%b required=0", perr_21); end
        ready_21 = 1'b1;
        cyc();
        ready_21 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_parity_error();
        test_overrun();
        test_reset_midframe();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
